// File: rtl/hack_control_seq_pkg.sv
// hack_control_seq_pkg: sequencer state encoding and Hack instruction field layout.
// The HALT state and the fixed-bit check exist only when ILLEGAL_TRAP_EN is defined.
package hack_control_seq_pkg;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMWR  = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // C-instructions must carry 11 in bits 14:13
  localparam int FIX_HI = 14;
  localparam int FIX_LO = 13;
  localparam logic [1:0] C_FIXED_BITS = 2'b11;
`else
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMWR  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;
`endif

  // instruction type: 0 = A-instruction, 1 = C-instruction
  localparam int TYPE_BIT = 15;

  // C-instruction fields
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

  // dest bits d1..d3
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;

  // jump bits j1..j3 within the 3-bit jump field
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

endpackage

// File: rtl/hack_jump_eval.sv
// hack_jump_eval: combinational jump condition from the latched ALU flags.
module hack_jump_eval
  import hack_control_seq_pkg::*;
(
  input  logic       zr,
  input  logic       ng,
  input  logic [2:0] j,
  output logic       jmp
);

  // a positive result is one that is neither zero nor negative
  always_comb begin
    jmp = (j[JMP_LT] & ng) | (j[JMP_EQ] & zr) | (j[JMP_GT] & ~ng & ~zr);
  end

endmodule

// File: rtl/hack_control_seq.sv
// hack_control_seq: multi-cycle sequencer driving the Hack ALU control interface.
// Optional macro ILLEGAL_TRAP_EN adds the 'illegal' output and a HALT trap state
// for C-instructions whose bits 14:13 are not 11.
module hack_control_seq
  import hack_control_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  input  logic [15:0]      alu_out,
  output logic             zx,
  output logic             nx,
  output logic             zy,
  output logic             ny,
  output logic             f,
  output logic             no,
  output logic             sel_m,
  output logic [15:0]      wb_data,
  output logic             load_a,
  output logic             load_d,
  output logic             write_m,
  input  logic             mem_ready,
  output logic             pc_load,
  output logic             pc_inc,
  output logic [CNT_W-1:0] retired
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  state_t      state;
  state_t      next_state;
  logic [12:0] instr_q;
  logic        c_q;
  logic        zr;
  logic        ng;
  logic        jmp;

  hack_jump_eval u_jump_eval (
    .zr  (zr),
    .ng  (ng),
    .j   (instr_q[JUMP_HI:JUMP_LO]),
    .jmp (jmp)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= next_state;
  end

  // next-state decode and the per-state handshake / pulse outputs
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    write_m     = 1'b0;
    load_a      = 1'b0;
    load_d      = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal     = 1'b0;
`endif
    case (state)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (instr[TYPE_BIT]) begin
`ifdef ILLEGAL_TRAP_EN
            next_state = (instr[FIX_HI:FIX_LO] == C_FIXED_BITS) ? ST_DECODE : ST_HALT;
`else
            next_state = ST_DECODE;
`endif
          end else begin
            next_state = ST_COMMIT;
          end
        end
      end
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC:   next_state = instr_q[DEST_M] ? ST_MEMWR : ST_COMMIT;
      ST_MEMWR: begin
        write_m = 1'b1;
        if (mem_ready) next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        next_state = ST_FETCH;
        if (c_q) begin
          load_a  = instr_q[DEST_A];
          load_d  = instr_q[DEST_D];
          pc_load = jmp;
          pc_inc  = ~jmp;
        end else begin
          load_a  = 1'b1;
          pc_inc  = 1'b1;
        end
      end
`ifdef ILLEGAL_TRAP_EN
      ST_HALT: illegal = 1'b1;
`endif
      default: next_state = ST_FETCH;
    endcase
  end

  // instruction latch, ALU controls, writeback value, flags and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      c_q     <= 1'b0;
      zx      <= 1'b0;
      nx      <= 1'b0;
      zy      <= 1'b0;
      ny      <= 1'b0;
      f       <= 1'b0;
      no      <= 1'b0;
      sel_m   <= 1'b0;
      wb_data <= '0;
      zr      <= 1'b0;
      ng      <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (instr_valid) begin
            instr_q <= instr[12:0];
            c_q     <= instr[TYPE_BIT];
            if (!instr[TYPE_BIT]) wb_data <= {1'b0, instr[14:0]};
          end
        end
        ST_DECODE: begin
          {zx, nx, zy, ny, f, no} <= instr_q[COMP_HI:COMP_LO];
          sel_m                   <= instr_q[A_BIT];
        end
        ST_EXEC: begin
          wb_data <= alu_out;
          zr      <= (alu_out == 16'h0000);
          ng      <= alu_out[15];
        end
        ST_COMMIT: retired <= retired + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_control_seq.sv
// tb_hack_control_seq: directed and randomized instruction stream against a
// transaction-level model of the Hack sequencer. Uses a narrow retire counter
// so counter wrap is exercised.
module tb_hack_control_seq;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                instr_valid;
  logic [15:0]         instr;
  logic                instr_ready;
  logic [15:0]         alu_out;
  logic                zx, nx, zy, ny, f, no;
  logic                sel_m;
  logic [15:0]         wb_data;
  logic                load_a, load_d, write_m;
  logic                mem_ready;
  logic                pc_load, pc_inc;
  logic [TB_CNT_W-1:0] retired;
`ifdef ILLEGAL_TRAP_EN
  logic                illegal;
`endif

  int       compared = 0;
  int       mismatched = 0;
  int       retired_count = 0;
  logic [6:0] ctrl_model = 7'd0;

  hack_control_seq #(.CNT_W(TB_CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_out     (alu_out),
    .zx          (zx),
    .nx          (nx),
    .zy          (zy),
    .ny          (ny),
    .f           (f),
    .no          (no),
    .sel_m       (sel_m),
    .wb_data     (wb_data),
    .load_a      (load_a),
    .load_d      (load_d),
    .write_m     (write_m),
    .mem_ready   (mem_ready),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .retired     (retired)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal     (illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expected_retired();
    return retired_count % (1 << TB_CNT_W);
  endfunction

  // Model: Hack jump semantics on the signed ALU result
  function automatic logic model_jump(input logic [15:0] v, input logic [2:0] j);
    int s;
    s = $signed(v);
    return (j[2] && s < 0) || (j[1] && s == 0) || (j[0] && s > 0);
  endfunction

  // Issue one instruction from FETCH (called at a negedge) and check it through commit
  task automatic applyStimulus(input logic [15:0] ins, input logic [15:0] alu, input int waits);
    int          edges;
    int          mw;
    bit          done;
    bit          stable;
    bit          ready_leak;
    logic [15:0] wb_first;
    logic [15:0] exp_wb;
    logic        exp_la, exp_ld, exp_pl, exp_pi;
    int          exp_edges, exp_mw;

    checkOutput("ready_in_fetch", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = ins;
    alu_out     = alu;
    mem_ready   = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    edges = 1; mw = 0; done = 0; stable = 1; ready_leak = 0; wb_first = '0;
    while (!done && edges < 64) begin
      if (pc_load || pc_inc) begin
        done = 1;
      end else begin
        if (instr_ready) ready_leak = 1;
        if (write_m) begin
          if (mw == 0) wb_first = wb_data;
          else if (wb_data !== wb_first) stable = 0;
          mem_ready = (mw >= waits);
          mw++;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        edges++;
      end
    end
    checkOutput("commit_seen", done, 1);
    if (!done) return;

    if (!ins[15]) begin
      exp_wb = {1'b0, ins[14:0]};
      exp_la = 1; exp_ld = 0; exp_pl = 0; exp_pi = 1;
      exp_edges = 1; exp_mw = 0;
    end else begin
      exp_wb = alu;
      exp_la = ins[5]; exp_ld = ins[4];
      exp_pl = model_jump(alu, ins[2:0]);
      exp_pi = !exp_pl;
      exp_mw = ins[3] ? waits + 1 : 0;
      exp_edges = 3 + exp_mw;
      ctrl_model = ins[12:6];
    end

    checkOutput("latency", edges, exp_edges);
    checkOutput("memwr_cycles", mw, exp_mw);
    if (mw > 0) begin
      checkOutput("memwr_wb_data", wb_first, exp_wb);
      checkOutput("memwr_wb_stable", stable, 1);
    end
    checkOutput("ready_low_busy", ready_leak, 0);
    checkOutput("commit_wb_data", wb_data, exp_wb);
    checkOutput("commit_load_a", load_a, exp_la);
    checkOutput("commit_load_d", load_d, exp_ld);
    checkOutput("commit_pc_load", pc_load, exp_pl);
    checkOutput("commit_pc_inc", pc_inc, exp_pi);
    checkOutput("commit_write_m", write_m, 0);
    checkOutput("alu_ctrl", {sel_m, zx, nx, zy, ny, f, no}, ctrl_model);

    retired_count++;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("retired", retired, expected_retired());
    checkOutput("ready_after_commit", instr_ready, 1);
    checkOutput("no_pulse_after_commit", {load_a, load_d, pc_load, pc_inc, write_m}, 0);
  endtask

  // Abort an M-writing instruction with reset while it waits in MEMWR
  task automatic resetDuringWrite();
    int guard;
    checkOutput("ready_before_abort", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = 16'hE7C8;
    alu_out     = 16'h1234;
    mem_ready   = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    guard = 0;
    while (!write_m && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("memwr_reached", write_m, 1);
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    retired_count = 0;
    ctrl_model    = 7'd0;
    checkOutput("abort_ready", instr_ready, 1);
    checkOutput("abort_pulses", {load_a, load_d, pc_load, pc_inc, write_m}, 0);
    checkOutput("abort_ctrl", {sel_m, zx, nx, zy, ny, f, no}, 0);
    checkOutput("abort_wb_data", wb_data, 0);
    checkOutput("abort_retired", retired, 0);
    @(negedge clk);
    checkOutput("abort_quiet", {load_a, load_d, pc_load, pc_inc, write_m}, 0);
    checkOutput("abort_ready_hold", instr_ready, 1);
  endtask

  initial begin
    logic [15:0] ins;
    logic [15:0] alu;
    int          waits;

    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    alu_out     = 16'h0000;
    mem_ready   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset_ready", instr_ready, 1);
    checkOutput("reset_pulses", {load_a, load_d, pc_load, pc_inc, write_m}, 0);
    checkOutput("reset_ctrl", {sel_m, zx, nx, zy, ny, f, no}, 0);
    checkOutput("reset_wb_data", wb_data, 0);
    checkOutput("reset_retired", retired, 0);

    $display("[TB] directed instructions");
    applyStimulus(16'h0007, 16'hAAAA, 0);
    applyStimulus(16'hEC10, 16'h0005, 0);
    applyStimulus(16'hE7C8, 16'h0042, 3);
    applyStimulus(16'hEA87, 16'h0000, 0);
    applyStimulus(16'hE301, 16'h8000, 0);
    applyStimulus(16'hE302, 16'h0000, 1);
    applyStimulus(16'h7FFF, 16'h0000, 0);

    $display("[TB] randomized instructions");
    for (int n = 0; n < 250; n++) begin
      ins = 16'($urandom);
      ins[15] = ($urandom_range(0, 3) != 0);
`ifdef ILLEGAL_TRAP_EN
      if (ins[15]) ins[14:13] = 2'b11;
`endif
      case ($urandom_range(0, 3))
        0:       alu = 16'h0000;
        1:       alu = 16'h8000 | 16'($urandom);
        2:       alu = 16'($urandom) & 16'h7FFF;
        default: alu = 16'($urandom);
      endcase
      waits = $urandom_range(0, 3);
      applyStimulus(ins, alu, waits);
    end

    $display("[TB] reset during memory write");
    resetDuringWrite();
    applyStimulus(16'h0003, 16'h0000, 0);

`ifdef ILLEGAL_TRAP_EN
    $display("[TB] illegal C-instruction trap");
    checkOutput("trap_ready_before", instr_ready, 1);
    instr_valid = 1'b1;
    instr       = 16'h8000;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      instr_valid = 1'b1;
      checkOutput("trap_illegal", illegal, 1);
      checkOutput("trap_ready", instr_ready, 0);
      checkOutput("trap_pulses", {load_a, load_d, pc_load, pc_inc, write_m}, 0);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    checkOutput("trap_retired", retired, expected_retired());
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    retired_count = 0;
    checkOutput("trap_cleared", illegal, 0);
    checkOutput("trap_ready_after", instr_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
